demux_rr_sched: RTL
===================

// Module: demux_rr_sched
// PURPOSE
//  Round-robin scheduler and output register for the 4-bit 1:4 demultiplexer datapath.
//  Accepts a valid/ready word stream, owns the 2-bit select, and steers words to one of
//  four valid/ready sink channels. Sends BURST_LEN words to a channel, then rotates to
//  the next enabled channel. Sits between a single producer and four consumers.
// PARAMETERS
//  W          4   data width of input word and of each channel
//  BURST_LEN  4   words sent per grant before rotating (>=1)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  chan_en    in   4    channel enable mask; bit k enables channel k (k=0..3)
//  in_data    in   W    input word
//  in_valid   in   1    input word valid
//  in_ready   out  1    block can accept a word this cycle
//  ch_data    out  4*W  channel k data = ch_data[k*W +: W]; non-selected channels = 0
//  ch_valid   out  4    one-hot (or 0) channel valid
//  ch_ready   in   4    per-channel sink ready
//  sel        out  2    channel currently granted (scheduler pointer)
//  busy       out  1    1 when holding a word or when state = BURST
//  cnt_clr    in   1    synchronous clear of delivery counters (feature only)
//  cnt_o      out  32   delivery counters, channel k = cnt_o[k*8 +: 8] (feature only)
// BEHAVIOUR
//  - Reset: in_ready=0, ch_valid=0, ch_data=0, sel=0, busy=0, cnt_o=0, state=IDLE,
//    burst count=0. The held word is discarded. Async assert; deassert acts on the next clk.
//  - Output stage: one register holding {data, dest}. ch_valid[dest]=hold_v.
//    Drain: hold_v & ch_ready[dest]. in_ready = (state==BURST) & chan_en[sel] &
//    (!hold_v | drain). Accept = in_valid & in_ready.
//  - Latency: word accepted at edge N is on ch_data/ch_valid after edge N. Throughput is
//    1 word/cycle when the sink holds ready high.
//  - dest is latched from sel at accept. Later sel/chan_en changes do not redirect a
//    held word. A held word waits indefinitely for its sink, even if that channel is now
//    disabled.
//  - FSM: IDLE: chan_en==0; in_ready=0. When chan_en!=0, move to BURST next cycle with
//    sel = lowest enabled index >= sel, wrapping 3->0.
//    BURST: each accept increments bcnt. When an accept brings bcnt to BURST_LEN, reset
//    bcnt=0 and advance sel to the next enabled channel after sel (wrap 3->0; may be sel
//    itself if it is the only enabled channel). If chan_en[sel]==0 with no accept, advance
//    sel and clear bcnt the same cycle. If chan_en==0, go to IDLE and clear bcnt.
//  - A stalled sink (ch_ready=0) does not advance bcnt or sel. The grant is word-counted,
//    not time-counted.
//  - Simultaneous drain and accept in one cycle is legal. Register reloads and
//    ch_valid stays high.
//  - bcnt width is $clog2(BURST_LEN+1). BURST_LEN=1 gives pure per-word round robin.
// CONFIGURATION
//  DEMUX_RR_SCHED_CNT_EN defined:
//    - Four 8-bit counters, each incremented on a drain of its channel. 255 wraps to 0.
//    - cnt_clr=1 zeroes all four at the next edge; this takes priority over an increment
//      in the same cycle.
//  DEMUX_RR_SCHED_CNT_EN undefined:
//    - No counter logic. cnt_o is tied to 0 and cnt_clr is ignored. Ports remain present.
// TESTING
//  1 Reset: rst_n=0 mid-stream with hold_v=1 -> all outputs 0 immediately; after release
//    with chan_en=4'hF, the first accepted word goes to ch0.
//  2 Rotation: BURST_LEN=4, chan_en=4'hF, ch_ready=4'hF, 16 words 0..F back-to-back ->
//    0-3 on ch0, 4-7 ch1, 8-B ch2, C-F ch3; one word/cycle; sel ends at 0.
//  3 Skip: chan_en=4'b1010, 8 words -> words 0-3 on ch1, 4-7 on ch3; ch0/ch2 never valid.
//  4 Backpressure: ch_ready[0]=0 for 5 cycles with word 0x9 held -> ch_data[3:0]=9 and
//    ch_valid=0001 stable; in_ready=0; bcnt frozen. Release -> resumes with no loss or
//    duplication.
//  5 Disable mid-burst: after 2 words to ch1, clear chan_en[1] -> held word still
//    delivered to ch1; next accept goes to ch2; chan_en=0 -> IDLE, in_ready=0.
//  6 Counters (macro on): 300 words all to ch0 (chan_en=0001) -> cnt_o[7:0]=44 (wrap);
//    cnt_clr on a drain cycle -> 0. Macro off -> cnt_o=0 throughout.

Source files
------------

// File: rtl/demux_rr_sched_if.sv
// Handshake bundle between one word producer and the four sink channels of demux_rr_sched.
// Producer/sink side uses modport master; the scheduler uses modport slave.
interface demux_rr_sched_if #(
   parameter int W = 4
);
   logic [3:0]     chan_en;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic [4*W-1:0] ch_data;
   logic [3:0]     ch_valid;
   logic [3:0]     ch_ready;
   logic [1:0]     sel;
   logic           busy;
   logic           cnt_clr;
   logic [31:0]    cnt_o;

   modport master (
      output chan_en, in_data, in_valid, ch_ready, cnt_clr,
      input  in_ready, ch_data, ch_valid, sel, busy, cnt_o
   );

   modport slave (
      input  chan_en, in_data, in_valid, ch_ready, cnt_clr,
      output in_ready, ch_data, ch_valid, sel, busy, cnt_o
   );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin 1:4 word demultiplexer: one output register, BURST_LEN words per grant.
// Define DEMUX_RR_SCHED_CNT_EN to build the four 8-bit per-channel delivery counters.
module demux_rr_sched #(
   parameter int W         = 4,
   parameter int BURST_LEN = 4
) (
   input logic             clk,
   input logic             rst_n,
   demux_rr_sched_if.slave bus
);
   localparam int BW = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    sel_reg, sel_next;
   logic [BW-1:0] bcnt_reg, bcnt_next;
   logic          hold_v_reg;
   logic [W-1:0]  hold_data_reg;
   logic [1:0]    hold_dest_reg;
   logic [3:0]    ch_valid_w;
   logic          drain, accept, in_ready_w;

   // First enabled channel scanning start, start+1, ... with wrap; start if none.
   function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
      logic [1:0] r;
      r = start;
      for (int i = 3; i >= 0; i--) begin
         if (mask[2'(start + 2'(i))]) r = 2'(start + 2'(i));
      end
      return r;
   endfunction

   assign drain      = hold_v_reg & bus.ch_ready[hold_dest_reg];
   assign in_ready_w = (state_reg == BURST) & bus.chan_en[sel_reg] & (~hold_v_reg | drain);
   assign accept     = bus.in_valid & in_ready_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         sel_reg   <= 2'd0;
         bcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         bcnt_reg  <= bcnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      bcnt_next  = bcnt_reg;
      case (state_reg)
         IDLE: begin
            if (|bus.chan_en) begin
               state_next = BURST;
               sel_next   = pick(bus.chan_en, sel_reg);
               bcnt_next  = '0;
            end
         end
         BURST: begin
            if (bus.chan_en == 4'd0) begin
               state_next = IDLE;
               bcnt_next  = '0;
            end else if (accept) begin
               if (bcnt_reg == BW'(BURST_LEN - 1)) begin
                  bcnt_next = '0;
                  sel_next  = pick(bus.chan_en, sel_reg + 2'd1);
               end else begin
                  bcnt_next = bcnt_reg + 1'b1;
               end
            end else if (!bus.chan_en[sel_reg]) begin
               // granted channel was withdrawn: move on without waiting for a word
               sel_next  = pick(bus.chan_en, sel_reg + 2'd1);
               bcnt_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Destination is frozen at accept so a held word is never redirected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_v_reg    <= 1'b0;
         hold_data_reg <= '0;
         hold_dest_reg <= 2'd0;
      end else if (accept) begin
         hold_v_reg    <= 1'b1;
         hold_data_reg <= bus.in_data;
         hold_dest_reg <= sel_reg;
      end else if (drain) begin
         hold_v_reg    <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         assign ch_valid_w[gi]        = hold_v_reg & (hold_dest_reg == 2'(gi));
         assign bus.ch_data[gi*W +: W] = ch_valid_w[gi] ? hold_data_reg : '0;
      end
   endgenerate

   assign bus.ch_valid = ch_valid_w;
   assign bus.in_ready = in_ready_w;
   assign bus.sel      = sel_reg;
   assign bus.busy     = hold_v_reg | (state_reg == BURST);

`ifdef DEMUX_RR_SCHED_CNT_EN
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cnt
         logic [7:0] cnt_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               cnt_reg <= 8'd0;
            else if (bus.cnt_clr)
               cnt_reg <= 8'd0;
            else if (drain && hold_dest_reg == 2'(gi))
               cnt_reg <= cnt_reg + 8'd1;
         end
         assign bus.cnt_o[gi*8 +: 8] = cnt_reg;
      end
   endgenerate
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = bus.cnt_clr;
   assign bus.cnt_o      = 32'd0;
`endif
endmodule
